obj_cmd_issuer: RTL

- Sits directly upstream of the object unit. Accepts decoded object commands (create, delete, delete-all, reference-address) from the VPU decode stage and buffers them in a small FIFO.
- Drives the object unit's single-cycle command pulses (crt_obj, del_obj, del_all, ref_addr, obj_num) one command at a time.
- Waits for addr_vld on create/reference commands, then releases the next command.
- Reports busy and timeout status back to decode and keeps a live-object count.

---
 rtl/obj_pkg.sv | 19 +
 rtl/obj_cmd_fifo.sv | 56 +++++
 rtl/obj_cmd_issuer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - shared command types for the object-unit command issuer
package obj_pkg;

  localparam int OBJ_W    = 5;
  localparam int MAX_OBJS = 32;

  typedef enum logic [1:0] {
    OP_CRT    = 2'b00,
    OP_DEL    = 2'b01,
    OP_DELALL = 2'b10,
    OP_REF    = 2'b11
  } obj_op_e;

  typedef struct packed {
    obj_op_e          op;
    logic [OBJ_W-1:0] obj_num;
  } obj_cmd_t;

endpackage

// File: rtl/obj_cmd_fifo.sv
// rtl/obj_cmd_fifo.sv - registered command FIFO, no bypass, pointers wrap modulo DEPTH
module obj_cmd_fifo
  import obj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  obj_cmd_t                   push_data,
  input  logic                       pop,
  output obj_cmd_t                   pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  obj_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // a push while full is dropped; the writer saw cmd_rdy low
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // storage array needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obj_cmd_issuer.sv
// rtl/obj_cmd_issuer.sv - buffers decoded object commands and issues one pulse per command
module obj_cmd_issuer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int OBJ_W       = 5,
  parameter int VLD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  input  logic [1:0]       cmd_op,
  input  logic [OBJ_W-1:0] cmd_obj_num,
  output logic             cmd_rdy,
  output logic             crt_obj,
  output logic             del_obj,
  output logic             del_all,
  output logic             ref_addr,
  output logic [OBJ_W-1:0] obj_num,
  input  logic             addr_vld,
  output logic             busy,
  output logic             timeout_err,
  output logic [OBJ_W:0]   obj_cnt
);

  import obj_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(VLD_TIMEOUT) + 1;
  localparam logic [OBJ_W:0] CNT_MAX = {1'b1, {OBJ_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_VLD, S_GAP} state_e;

  state_e          state;
  obj_op_e         cur_op;
  logic [TW-1:0]   tcnt;
  obj_cmd_t        push_cmd;
  obj_cmd_t        head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;

  assign push_cmd = '{op: obj_op_e'(cmd_op), obj_num: cmd_obj_num};
  assign cmd_rdy  = !fifo_full;
  assign fifo_pop = (state == S_IDLE) && !fifo_empty;
  assign busy     = (fifo_count != '0) || (state != S_IDLE);

  obj_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_vld),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // issue FSM: pulses are registered on the IDLE->ISSUE edge so they are high exactly in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_op      <= OP_CRT;
      tcnt        <= '0;
      crt_obj     <= 1'b0;
      del_obj     <= 1'b0;
      del_all     <= 1'b0;
      ref_addr    <= 1'b0;
      obj_num     <= '0;
      timeout_err <= 1'b0;
      obj_cnt     <= '0;
    end else begin
      crt_obj  <= 1'b0;
      del_obj  <= 1'b0;
      del_all  <= 1'b0;
      ref_addr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_op   <= head.op;
            // create and delete-all carry no object number
            obj_num  <= (head.op == OP_DEL || head.op == OP_REF) ? head.obj_num : '0;
            crt_obj  <= (head.op == OP_CRT);
            del_obj  <= (head.op == OP_DEL);
            del_all  <= (head.op == OP_DELALL);
            ref_addr <= (head.op == OP_REF);
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          case (cur_op)
            OP_DEL: begin
              if (obj_cnt != '0) obj_cnt <= obj_cnt - 1'b1;
              state <= S_GAP;
            end
            OP_DELALL: begin
              obj_cnt <= '0;
              state   <= S_GAP;
            end
            default: state <= S_WAIT_VLD;
          endcase
        end
        S_WAIT_VLD: begin
          // addr_vld gets VLD_TIMEOUT samples before the command is abandoned
          if (addr_vld) begin
            if (cur_op == OP_CRT && obj_cnt != CNT_MAX) obj_cnt <= obj_cnt + 1'b1;
            state <= S_GAP;
          end else if (tcnt == TW'(VLD_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
